// File: rtl/keystone_axil_regs_pkg.sv
// Shared definitions for the keystone control/status register block:
// register offsets, bus response codes and corner-coefficient geometry.
package keystone_pkg;

    localparam int unsigned CORNER_W     = 16;
    localparam int unsigned NUM_CORNERS  = 8;
    localparam int unsigned CORNER_IDX_W = $clog2(NUM_CORNERS);

    localparam logic [31:0] OFF_CTRL    = 32'h00;
    localparam logic [31:0] OFF_STATUS  = 32'h04;
    localparam logic [31:0] OFF_CORNER0 = 32'h08;
    localparam logic [31:0] OFF_CORNER1 = 32'h0C;
    localparam logic [31:0] OFF_CORNER2 = 32'h10;
    localparam logic [31:0] OFF_CORNER3 = 32'h14;
    localparam logic [31:0] OFF_CORNER4 = 32'h18;
    localparam logic [31:0] OFF_CORNER5 = 32'h1C;
    localparam logic [31:0] OFF_CORNER6 = 32'h20;
    localparam logic [31:0] OFF_CORNER7 = 32'h24;
    localparam logic [31:0] OFF_ID      = 32'h28;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef struct packed {
        logic                    hit;
        logic [CORNER_IDX_W-1:0] idx;
    } corner_sel_t;

    function automatic corner_sel_t decodeCorner(input logic [31:0] off);
        corner_sel_t sel;
        sel     = '0;
        sel.hit = 1'b1;
        case (off)
            OFF_CORNER0: sel.idx = CORNER_IDX_W'(0);
            OFF_CORNER1: sel.idx = CORNER_IDX_W'(1);
            OFF_CORNER2: sel.idx = CORNER_IDX_W'(2);
            OFF_CORNER3: sel.idx = CORNER_IDX_W'(3);
            OFF_CORNER4: sel.idx = CORNER_IDX_W'(4);
            OFF_CORNER5: sel.idx = CORNER_IDX_W'(5);
            OFF_CORNER6: sel.idx = CORNER_IDX_W'(6);
            OFF_CORNER7: sel.idx = CORNER_IDX_W'(7);
            default:     sel.hit = 1'b0;
        endcase
        return sel;
    endfunction

    // Only the two low byte lanes exist in a 16-bit coefficient.
    function automatic logic [CORNER_W-1:0] applyStrb(input logic [CORNER_W-1:0] oldVal,
                                                      input logic [CORNER_W-1:0] newVal,
                                                      input logic [1:0]          strb);
        logic [CORNER_W-1:0] res;
        res = oldVal;
        if (strb[0]) res[7:0]  = newVal[7:0];
        if (strb[1]) res[15:8] = newVal[15:8];
        return res;
    endfunction

endpackage

// File: rtl/keystone_axil_regs_if.sv
// AXI4-Lite bus bundle between software master and the keystone register block.
interface keystone_axil_regs_if
    import keystone_pkg::*;
#(
    parameter int unsigned ADDR_W = 6
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    resp_t             bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    resp_t             rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/keystone_axil_regs_rst_pulse.sv
// Software-reset pulse stretcher: load restarts a down-counter, output is high while it runs.
module keystone_rst_pulse #(
    parameter int unsigned RST_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    output logic active_o
);
    localparam int unsigned CNT_W = $clog2(RST_CYCLES + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = CNT_W'(RST_CYCLES);
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign active_o = (count_q != '0);

endmodule

// File: rtl/keystone_axil_regs.sv
// AXI4-Lite control/status registers for the keystone-correction core.
// Optional KEYSTONE_SHADOW_EN: corner coefficients reach corner_out only at frame start.
module keystone_axil_regs
    import keystone_pkg::*;
#(
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned RST_CYCLES = 16,
    parameter logic [31:0] ID_VALUE   = 32'h4B53_0001
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    keystone_axil_regs_if.slave              s_axi,
    input  logic [31:0]                      status_in,
    input  logic                             frame_start_in,
    output logic                             sw_en_out,
    output logic                             sw_rst_out,
    output logic [CORNER_W*NUM_CORNERS-1:0]  corner_out
);

    logic                ready_q;
    logic                awHeld_q;
    logic                wHeld_q;
    logic [ADDR_W-1:0]   awAddr_q;
    logic [CORNER_W-1:0] wData_q;
    logic [1:0]          wStrb_q;
    logic                bvalid_q;
    resp_t               bresp_q;
    logic                rvalid_q;
    resp_t               rresp_q;
    logic [31:0]         rdata_q;
    logic                ctrlEn_q;
    logic [CORNER_W-1:0] corner_q [NUM_CORNERS];

    logic                awFire;
    logic                wFire;
    logic                arFire;
    logic                doWrite;
    logic [31:0]         wOff;
    logic [31:0]         rOff;
    corner_sel_t         wrSel;
    corner_sel_t         rdSel;
    logic                wrCtrl;
    resp_t               wrResp;
    logic [31:0]         rdNext;
    resp_t               rdResp;
    logic                pulseLoad;
    logic [CORNER_W*NUM_CORNERS-1:0] cornerPacked;
    logic                unusedWriteBits;

    assign unusedWriteBits = ^{s_axi.wdata[31:16], s_axi.wstrb[3:2]};

    assign s_axi.awready = ready_q & ~awHeld_q;
    assign s_axi.wready  = ready_q & ~wHeld_q;
    assign s_axi.arready = ready_q & ~rvalid_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;

    assign awFire  = s_axi.awvalid & s_axi.awready;
    assign wFire   = s_axi.wvalid & s_axi.wready;
    assign arFire  = s_axi.arvalid & s_axi.arready;
    assign doWrite = awHeld_q & wHeld_q & ~bvalid_q;

    assign wOff  = 32'(awAddr_q) & ~32'h3;
    assign rOff  = 32'(s_axi.araddr) & ~32'h3;
    assign wrSel = decodeCorner(wOff);
    assign rdSel = decodeCorner(rOff);

    always_comb begin
        wrCtrl = 1'b0;
        wrResp = OKAY;
        if (wOff == OFF_CTRL) begin
            wrCtrl = 1'b1;
        end else if (!wrSel.hit) begin
            wrResp = SLVERR;
        end
    end

    // Reads sample current register state, so a coincident write is not yet visible.
    always_comb begin
        rdNext = '0;
        rdResp = OKAY;
        if (rOff == OFF_CTRL) begin
            rdNext = {30'b0, sw_rst_out, ctrlEn_q};
        end else if (rOff == OFF_STATUS) begin
            rdNext = status_in;
        end else if (rdSel.hit) begin
            rdNext = {16'b0, corner_q[rdSel.idx]};
        end else if (rOff == OFF_ID) begin
            rdNext = ID_VALUE;
        end else begin
            rdResp = SLVERR;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_q  <= 1'b0;
            awHeld_q <= 1'b0;
            wHeld_q  <= 1'b0;
            awAddr_q <= '0;
            wData_q  <= '0;
            wStrb_q  <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= OKAY;
            rdata_q  <= '0;
        end else begin
            ready_q <= 1'b1;
            if (awFire) begin
                awHeld_q <= 1'b1;
                awAddr_q <= s_axi.awaddr;
            end else if (doWrite) begin
                awHeld_q <= 1'b0;
            end
            if (wFire) begin
                wHeld_q <= 1'b1;
                wData_q <= s_axi.wdata[CORNER_W-1:0];
                wStrb_q <= s_axi.wstrb[1:0];
            end else if (doWrite) begin
                wHeld_q <= 1'b0;
            end
            if (doWrite) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wrResp;
            end else if (bvalid_q && s_axi.bready) begin
                bvalid_q <= 1'b0;
            end
            if (arFire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdNext;
                rresp_q  <= rdResp;
            end else if (rvalid_q && s_axi.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ctrlEn_q <= 1'b0;
            for (int i = 0; i < int'(NUM_CORNERS); i++) begin
                corner_q[i] <= '0;
            end
        end else if (doWrite) begin
            if (wrCtrl && wStrb_q[0]) begin
                ctrlEn_q <= wData_q[0];
            end
            if (wrSel.hit) begin
                corner_q[wrSel.idx] <= applyStrb(corner_q[wrSel.idx], wData_q, wStrb_q);
            end
        end
    end

    assign pulseLoad = doWrite & wrCtrl & wStrb_q[0] & wData_q[1];

    keystone_rst_pulse #(
        .RST_CYCLES (RST_CYCLES)
    ) u_rst_pulse (
        .clk_i    (aclk),
        .rst_ni   (aresetn),
        .load_i   (pulseLoad),
        .active_o (sw_rst_out)
    );

    assign sw_en_out = ctrlEn_q;

    always_comb begin
        cornerPacked = '0;
        for (int i = 0; i < int'(NUM_CORNERS); i++) begin
            cornerPacked[i*CORNER_W +: CORNER_W] = corner_q[i];
        end
    end

`ifdef KEYSTONE_SHADOW_EN
    // corner_q acts as staging; the core only sees a new set at frame boundaries.
    logic [CORNER_W*NUM_CORNERS-1:0] cornerOut_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cornerOut_q <= '0;
        end else if (frame_start_in) begin
            cornerOut_q <= cornerPacked;
        end
    end

    assign corner_out = cornerOut_q;
`else
    logic unusedFrameStart;
    assign unusedFrameStart = frame_start_in;
    assign corner_out       = cornerPacked;
`endif

endmodule

// File: tb/tb_keystone_axil_regs.sv
// Directed self-checking bench for keystone_axil_regs (honours KEYSTONE_SHADOW_EN when defined).
module tb_keystone_axil_regs;
    import keystone_pkg::*;

    logic         aclk;
    logic         aresetn;
    logic [31:0]  status_in;
    logic         frame_start_in;
    logic         sw_en_out;
    logic         sw_rst_out;
    logic [127:0] corner_out;

    int checkCount = 0;
    int errorCount = 0;
    int rstHigh    = 0;

    keystone_axil_regs_if #(.ADDR_W(6)) bus ();

    keystone_axil_regs #(
        .ADDR_W     (6),
        .RST_CYCLES (16),
        .ID_VALUE   (32'h4B53_0001)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axi          (bus),
        .status_in      (status_in),
        .frame_start_in (frame_start_in),
        .sw_en_out      (sw_en_out),
        .sw_rst_out     (sw_rst_out),
        .corner_out     (corner_out)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (sw_rst_out) rstHigh++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic sendAw(input logic [5:0] addr);
        int n = 0;
        @(negedge aclk);
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        while (!bus.awready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        checkOutput("awReady", 32'(bus.awready), 32'd1);
        @(negedge aclk);
        bus.awvalid = 1'b0;
    endtask

    task automatic sendW(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        @(negedge aclk);
        bus.wdata  = data;
        bus.wstrb  = strb;
        bus.wvalid = 1'b1;
        while (!bus.wready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        checkOutput("wReady", 32'(bus.wready), 32'd1);
        @(negedge aclk);
        bus.wvalid = 1'b0;
    endtask

    task automatic waitB(output resp_t resp);
        int n = 0;
        while (!bus.bvalid && n < 50) begin
            @(negedge aclk);
            n++;
        end
        checkOutput("bvalidSeen", 32'(bus.bvalid), 32'd1);
        resp       = bus.bresp;
        bus.bready = 1'b1;
        @(negedge aclk);
        bus.bready = 1'b0;
        checkOutput("bvalidDrop", 32'(bus.bvalid), 32'd0);
    endtask

    task automatic applyStimulus(input logic [5:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, output resp_t resp);
        fork
            sendAw(addr);
            sendW(data, strb);
        join
        waitB(resp);
    endtask

    task automatic readReg(input logic [5:0] addr, output logic [31:0] data, output resp_t resp);
        int n = 0;
        @(negedge aclk);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        while (!bus.arready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        checkOutput("arReady", 32'(bus.arready), 32'd1);
        @(negedge aclk);
        bus.arvalid = 1'b0;
        checkOutput("rvalidLatency", 32'(bus.rvalid), 32'd1);
        data       = bus.rdata;
        resp       = bus.rresp;
        bus.rready = 1'b1;
        @(negedge aclk);
        bus.rready = 1'b0;
        checkOutput("rvalidDrop", 32'(bus.rvalid), 32'd0);
    endtask

    initial begin
        resp_t       resp;
        logic [31:0] data;
        int          base;

        aresetn        = 1'b0;
        status_in      = 32'hCAFE_0000;
        frame_start_in = 1'b0;
        bus.awaddr     = '0;
        bus.awvalid    = 1'b0;
        bus.wdata      = '0;
        bus.wstrb      = '0;
        bus.wvalid     = 1'b0;
        bus.bready     = 1'b0;
        bus.araddr     = '0;
        bus.arvalid    = 1'b0;
        bus.rready     = 1'b0;

        // Reset state
        repeat (2) @(negedge aclk);
        checkOutput("rstAwready", 32'(bus.awready), 32'd0);
        checkOutput("rstWready", 32'(bus.wready), 32'd0);
        checkOutput("rstArready", 32'(bus.arready), 32'd0);
        checkOutput("rstBvalid", 32'(bus.bvalid), 32'd0);
        checkOutput("rstRvalid", 32'(bus.rvalid), 32'd0);
        checkOutput("rstSwEn", 32'(sw_en_out), 32'd0);
        checkOutput("rstSwRst", 32'(sw_rst_out), 32'd0);
        checkOutput("rstCorner", 32'(|corner_out), 32'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        checkOutput("readyAfterRst", 32'({bus.awready, bus.wready, bus.arready}), 32'h7);

        // ID register
        readReg(6'h28, data, resp);
        checkOutput("idData", data, 32'h4B53_0001);
        checkOutput("idResp", 32'(resp), 32'(OKAY));

        // AW early, W three cycles later, two low byte lanes
        sendAw(6'h08);
        repeat (2) @(negedge aclk);
        checkOutput("bvalidWaitW", 32'(bus.bvalid), 32'd0);
        sendW(32'h1234_ABCD, 4'b0011);
        checkOutput("bvalidAtWEdge", 32'(bus.bvalid), 32'd0);
        @(negedge aclk);
        checkOutput("bvalidAfterW", 32'(bus.bvalid), 32'd1);
        waitB(resp);
        checkOutput("c0Bresp", 32'(resp), 32'(OKAY));
        readReg(6'h08, data, resp);
        checkOutput("c0Data", data, 32'h0000_ABCD);

        // Single lane, then no lanes, with address low bits set
        applyStimulus(6'h0A, 32'hFFFF_00EE, 4'b0001, resp);
        readReg(6'h08, data, resp);
        checkOutput("c0Lane0", data, 32'h0000_ABEE);
        applyStimulus(6'h08, 32'hFFFF_FFFF, 4'b0000, resp);
        checkOutput("strb0Resp", 32'(resp), 32'(OKAY));
        readReg(6'h08, data, resp);
        checkOutput("strb0Data", data, 32'h0000_ABEE);

        // CTRL enable plus software-reset pulse
        base = rstHigh;
        applyStimulus(6'h00, 32'h0000_0003, 4'hF, resp);
        checkOutput("ctrlResp", 32'(resp), 32'(OKAY));
        checkOutput("swEn", 32'(sw_en_out), 32'd1);
        readReg(6'h00, data, resp);
        checkOutput("ctrlDuringPulse", data, 32'h3);
        repeat (30) @(negedge aclk);
        checkOutput("pulseLength", 32'(rstHigh - base), 32'd16);
        checkOutput("pulseDone", 32'(sw_rst_out), 32'd0);
        readReg(6'h00, data, resp);
        checkOutput("ctrlAfterPulse", data, 32'h1);

        // Error responses and STATUS
        applyStimulus(6'h04, 32'h1, 4'hF, resp);
        checkOutput("wrStatusResp", 32'(resp), 32'(SLVERR));
        applyStimulus(6'h30, 32'h1, 4'hF, resp);
        checkOutput("wrUnmappedResp", 32'(resp), 32'(SLVERR));
        applyStimulus(6'h28, 32'h1, 4'hF, resp);
        checkOutput("wrIdResp", 32'(resp), 32'(SLVERR));
        readReg(6'h30, data, resp);
        checkOutput("rdUnmappedData", data, 32'h0);
        checkOutput("rdUnmappedResp", 32'(resp), 32'(SLVERR));
        readReg(6'h04, data, resp);
        checkOutput("status1", data, 32'hCAFE_0000);
        status_in = 32'h1357_9BDF;
        readReg(6'h04, data, resp);
        checkOutput("status2", data, 32'h1357_9BDF);
        checkOutput("statusResp", 32'(resp), 32'(OKAY));

        // Read and write of CORNER2 executing on the same edge
        @(negedge aclk);
        checkOutput("idleReady", 32'({bus.awready, bus.wready, bus.arready}), 32'h7);
        bus.awaddr  = 6'h10;
        bus.awvalid = 1'b1;
        bus.wdata   = 32'h0000_7777;
        bus.wstrb   = 4'hF;
        bus.wvalid  = 1'b1;
        @(negedge aclk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.araddr  = 6'h10;
        bus.arvalid = 1'b1;
        @(negedge aclk);
        bus.arvalid = 1'b0;
        checkOutput("rawRvalid", 32'(bus.rvalid), 32'd1);
        checkOutput("rawOldData", bus.rdata, 32'h0);
        checkOutput("rawBvalid", 32'(bus.bvalid), 32'd1);
        bus.rready = 1'b1;
        bus.bready = 1'b1;
        @(negedge aclk);
        bus.rready = 1'b0;
        bus.bready = 1'b0;
        readReg(6'h10, data, resp);
        checkOutput("rawNewData", data, 32'h0000_7777);

        // Write back-pressure on CORNER1
        fork
            sendAw(6'h0C);
            sendW(32'h0000_1111, 4'hF);
        join
        @(negedge aclk);
        checkOutput("bpFirstB", 32'(bus.bvalid), 32'd1);
        fork
            sendAw(6'h0C);
            sendW(32'h0000_2222, 4'hF);
        join
        repeat (3) @(negedge aclk);
        checkOutput("bpStillFirstB", 32'(bus.bvalid), 32'd1);
        checkOutput("bpAwHeld", 32'(bus.awready), 32'd0);
        checkOutput("bpWHeld", 32'(bus.wready), 32'd0);
        readReg(6'h0C, data, resp);
        checkOutput("bpNotExecuted", data, 32'h0000_1111);
        waitB(resp);
        checkOutput("bpResp1", 32'(resp), 32'(OKAY));
        waitB(resp);
        checkOutput("bpResp2", 32'(resp), 32'(OKAY));
        readReg(6'h0C, data, resp);
        checkOutput("bpExecuted", data, 32'h0000_2222);

        // CORNER3 reaching corner_out
        applyStimulus(6'h14, 32'h0000_0055, 4'hF, resp);
`ifdef KEYSTONE_SHADOW_EN
        checkOutput("shadowHold", 32'(corner_out[63:48]), 32'h0);
        repeat (3) @(negedge aclk);
        checkOutput("shadowStillHold", 32'(corner_out[63:48]), 32'h0);
        frame_start_in = 1'b1;
        @(negedge aclk);
        frame_start_in = 1'b0;
`endif
        checkOutput("cornerOut3", 32'(corner_out[63:48]), 32'h0055);
        checkOutput("cornerOut0", 32'(corner_out[15:0]), 32'hABEE);
        checkOutput("cornerOut1", 32'(corner_out[31:16]), 32'h2222);
        checkOutput("cornerOut2", 32'(corner_out[47:32]), 32'h7777);
        checkOutput("cornerOutHigh", 32'(|corner_out[127:64]), 32'd0);
        readReg(6'h14, data, resp);
        checkOutput("c3Read", data, 32'h0000_0055);

        // Reset asserted while a write response is pending
        fork
            sendAw(6'h00);
            sendW(32'h0000_0003, 4'hF);
        join
        @(negedge aclk);
        checkOutput("midBvalid", 32'(bus.bvalid), 32'd1);
        checkOutput("midSwRst", 32'(sw_rst_out), 32'd1);
        #2 aresetn = 1'b0;
        #1;
        checkOutput("midRstBvalid", 32'(bus.bvalid), 32'd0);
        checkOutput("midRstSwEn", 32'(sw_en_out), 32'd0);
        checkOutput("midRstSwRst", 32'(sw_rst_out), 32'd0);
        checkOutput("midRstReady", 32'({bus.awready, bus.wready, bus.arready}), 32'h0);
        checkOutput("midRstCorner", 32'(|corner_out), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        readReg(6'h00, data, resp);
        checkOutput("ctrlAfterRst", data, 32'h0);
        readReg(6'h08, data, resp);
        checkOutput("c0AfterRst", data, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
